// File: rtl/triumph_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// triumph_pkg
// Shared definitions for the Triumph hazard/issue controller:
//   - hz_state_e : FSM state encoding (RUN / STALL / FLUSH)
//   - REG_ADDR_W : register address width
//   - SB_CNT_W   : width of each per-register pending-write counter
// ---------------------------------------------------------------------------
package triumph_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int SB_CNT_W   = 2;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } hz_state_e;
endpackage

// File: rtl/triumph_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// triumph_hazard_ctrl_if
// Bundles the ID / EX / WB side signals of the hazard controller.
//   master : pipeline side (drives the ID/EX/WB status, receives decisions)
//   slave  : the hazard controller itself
// Parameter CNT_W sets the width of the stall performance counter.
// ---------------------------------------------------------------------------
interface triumph_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import triumph_pkg::*;

    logic                  id_valid_i;
    logic [REG_ADDR_W-1:0] id_rs1_addr_i;
    logic                  id_rs1_used_i;
    logic [REG_ADDR_W-1:0] id_rs2_addr_i;
    logic                  id_rs2_used_i;
    logic [REG_ADDR_W-1:0] id_rd_addr_i;
    logic                  id_rd_we_i;
    logic                  ex_busy_i;
    logic                  wb_valid_i;
    logic [REG_ADDR_W-1:0] wb_rd_addr_i;
    logic                  flush_req_i;

    logic                  id_issue_o;
    logic                  if_stall_o;
    logic                  id_flush_o;
    logic                  fwd_rs1_o;
    logic                  fwd_rs2_o;
    logic [CNT_W-1:0]      stall_cnt_o;

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i,
               id_rs2_used_i, id_rd_addr_i, id_rd_we_i, ex_busy_i,
               wb_valid_i, wb_rd_addr_i, flush_req_i,
        input  id_issue_o, if_stall_o, id_flush_o, fwd_rs1_o, fwd_rs2_o,
               stall_cnt_o
    );

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs1_used_i, id_rs2_addr_i,
               id_rs2_used_i, id_rd_addr_i, id_rd_we_i, ex_busy_i,
               wb_valid_i, wb_rd_addr_i, flush_req_i,
        output id_issue_o, if_stall_o, id_flush_o, fwd_rs1_o, fwd_rs2_o,
               stall_cnt_o
    );
endinterface

// File: rtl/triumph_hazard_ctrl_scoreboard.sv
// ---------------------------------------------------------------------------
// triumph_scoreboard
// Per-register pending-write counters for x1..x31 (x0 reads as always idle).
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   set_en / set_addr     : an issued instruction will write set_addr
//   clr_en / clr_addr     : WB writes clr_addr this cycle
//   rs1_addr / rs2_addr   : operand query addresses
//   rs*_pending           : operand register has an outstanding write
//   rs*_one               : exactly one write outstanding
//   rd_addr / rd_full     : destination counter is saturated
// ---------------------------------------------------------------------------
module triumph_scoreboard
    import triumph_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  set_en,
    input  logic [REG_ADDR_W-1:0] set_addr,
    input  logic                  clr_en,
    input  logic [REG_ADDR_W-1:0] clr_addr,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  rs1_pending,
    output logic                  rs1_one,
    output logic                  rs2_pending,
    output logic                  rs2_one,
    output logic                  rd_full
);
    logic [SB_CNT_W-1:0] cnt_vec [NUM_REGS];

    // x0 is hard-wired idle so queries on it never report a hazard.
    assign cnt_vec[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_reg
            logic [SB_CNT_W-1:0] cnt_reg;
            logic                inc;
            logic                dec;

            // The issue logic never lets a saturated counter be incremented,
            // the guard only keeps the counter from wrapping.
            assign inc = set_en && (set_addr == REG_ADDR_W'(gi)) && (cnt_reg != SB_CNT_MAX);
            // Write-backs to registers with nothing pending are ignored.
            assign dec = clr_en && (clr_addr == REG_ADDR_W'(gi)) && (cnt_reg != '0);

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    cnt_reg <= '0;
                end else if (inc && !dec) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end else if (dec && !inc) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end

            assign cnt_vec[gi] = cnt_reg;
        end
    endgenerate

    assign rs1_pending = (cnt_vec[rs1_addr] != '0);
    assign rs1_one     = (cnt_vec[rs1_addr] == SB_CNT_W'(1));
    assign rs2_pending = (cnt_vec[rs2_addr] != '0);
    assign rs2_one     = (cnt_vec[rs2_addr] == SB_CNT_W'(1));
    assign rd_full     = (cnt_vec[rd_addr] == SB_CNT_MAX);
endmodule

// File: rtl/triumph_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// triumph_hazard_ctrl
// Hazard and issue controller between ID and EX of the Triumph core.
// Gates ID->EX issue on RAW/WAW hazards and a busy EX unit, sequences the
// IF/ID flush after a taken branch and counts stall cycles.
// Ports:
//   clk_i : core clock
//   rst_i : asynchronous active-low reset
//   hz    : triumph_hazard_ctrl_if.slave (ID/EX/WB status in, decisions out)
// Parameters:
//   FLUSH_CYCLES : cycles ID stays flushed after a flush request (1..7)
//   CNT_W        : stall counter width
// Build option:
//   TRIUMPH_FWD_EN : enables WB->ID forwarding (fwd_rs1_o/fwd_rs2_o and the
//                    WB-cycle RAW exception); otherwise forwarding is off.
// ---------------------------------------------------------------------------
module triumph_hazard_ctrl
    import triumph_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    triumph_hazard_ctrl_if.slave  hz
);
    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    hz_state_e        state_reg, state_next;
    logic [2:0]       flush_cnt_reg, flush_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic rs1_pending, rs1_one, rs2_pending, rs2_one, rd_full;
    logic raw_rs1, raw_rs2, waw;
    logic fwd_rs1, fwd_rs2;
    logic in_flush, issue, stall, sb_set;

    assign sb_set = issue && hz.id_rd_we_i && (hz.id_rd_addr_i != '0);

    triumph_scoreboard u_scoreboard (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .set_en      (sb_set),
        .set_addr    (hz.id_rd_addr_i),
        .clr_en      (hz.wb_valid_i),
        .clr_addr    (hz.wb_rd_addr_i),
        .rs1_addr    (hz.id_rs1_addr_i),
        .rs2_addr    (hz.id_rs2_addr_i),
        .rd_addr     (hz.id_rd_addr_i),
        .rs1_pending (rs1_pending),
        .rs1_one     (rs1_one),
        .rs2_pending (rs2_pending),
        .rs2_one     (rs2_one),
        .rd_full     (rd_full)
    );

`ifdef TRIUMPH_FWD_EN
    logic wb_hit_rs1, wb_hit_rs2;
    assign wb_hit_rs1 = hz.wb_valid_i && hz.id_rs1_used_i && (hz.id_rs1_addr_i != '0)
                        && (hz.wb_rd_addr_i == hz.id_rs1_addr_i);
    assign wb_hit_rs2 = hz.wb_valid_i && hz.id_rs2_used_i && (hz.id_rs2_addr_i != '0)
                        && (hz.wb_rd_addr_i == hz.id_rs2_addr_i);
    // The last outstanding write is on the WB bus right now: take it from there.
    assign raw_rs1 = hz.id_rs1_used_i && rs1_pending && !(rs1_one && wb_hit_rs1);
    assign raw_rs2 = hz.id_rs2_used_i && rs2_pending && !(rs2_one && wb_hit_rs2);
    assign fwd_rs1 = wb_hit_rs1;
    assign fwd_rs2 = wb_hit_rs2;
`else
    logic unused_one;
    assign unused_one = rs1_one ^ rs2_one;
    assign raw_rs1 = hz.id_rs1_used_i && rs1_pending;
    assign raw_rs2 = hz.id_rs2_used_i && rs2_pending;
    assign fwd_rs1 = 1'b0;
    assign fwd_rs2 = 1'b0;
`endif

    assign waw      = hz.id_rd_we_i && rd_full;
    assign in_flush = hz.flush_req_i || (state_reg == FLUSH);
    assign issue    = hz.id_valid_i && !in_flush && !hz.ex_busy_i && !raw_rs1 && !raw_rs2 && !waw;
    assign stall    = hz.id_valid_i && !issue && !in_flush;

    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        if (hz.flush_req_i) begin
            state_next     = FLUSH;
            flush_cnt_next = FLUSH_LOAD;
        end else begin
            case (state_reg)
                RUN:     if (stall) state_next = STALL;
                STALL:   if (issue) state_next = RUN;
                FLUSH: begin
                    if (flush_cnt_reg == 3'd0) begin
                        state_next = RUN;
                    end else begin
                        flush_cnt_next = flush_cnt_reg - 3'd1;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg     <= RUN;
            flush_cnt_reg <= 3'd0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            if (stall && (stall_cnt_reg != '1)) begin
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
            end
        end
    end

    // Decisions are qualified with reset so nothing issues while held in reset.
    assign hz.id_issue_o  = rst_i && issue;
    assign hz.if_stall_o  = rst_i && stall;
    assign hz.id_flush_o  = rst_i && in_flush;
    assign hz.fwd_rs1_o   = rst_i && fwd_rs1;
    assign hz.fwd_rs2_o   = rst_i && fwd_rs2;
    assign hz.stall_cnt_o = stall_cnt_reg;
endmodule

// File: doc/triumph_hazard_ctrl.md
# triumph_hazard_ctrl

Pipeline hazard and issue controller for the Triumph core. It sits between the ID stage, the register file and the EX/WB stages, and gates each decoded instruction from ID into EX. It tracks in-flight register writes with a per-register scoreboard, stalls IF/ID on RAW/WAW hazards and on a busy multi-cycle EX unit, and sequences the IF/ID flush after a taken branch.

## Interface
- FLUSH_CYCLES, default 2: number of cycles ID is flushed after a flush request (1..7).
- CNT_W, default 16: width of the stall performance counter.

- clk_i  in  1  core clock; all state updates on the rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- id_valid_i  in  1  ID holds a decoded instruction.
- id_rs1_addr_i  in  5  rs1 address of the ID instruction.
- id_rs1_used_i  in  1  ID instruction reads rs1.
- id_rs2_addr_i  in  5  rs2 address of the ID instruction.
- id_rs2_used_i  in  1  ID instruction reads rs2.
- id_rd_addr_i  in  5  rd address of the ID instruction.
- id_rd_we_i  in  1  ID instruction writes rd.
- ex_busy_i  in  1  EX multi-cycle unit cannot accept a new op.
- wb_valid_i  in  1  WB writes the register file this cycle.
- wb_rd_addr_i  in  5  WB destination register.
- flush_req_i  in  1  taken branch/jump resolved in EX.
- id_issue_o  out  1  ID instruction moves to EX this cycle.
- if_stall_o  out  1  hold PC and the IF/ID register.
- id_flush_o  out  1  invalidate the IF/ID register.
- fwd_rs1_o  out  1  take rs1 from the WB data, not the regfile (forwarding builds only).
- fwd_rs2_o  out  1  take rs2 from the WB data, not the regfile (forwarding builds only).
- stall_cnt_o  out  CNT_W  saturating count of stall cycles.

## Operation
- Scoreboard: one 2-bit pending-write counter per register x1..x31. x0 is never tracked and never hazards.
  - Increment on id_issue_o && id_rd_we_i && rd!=0.
  - Decrement on wb_valid_i && wb_rd_addr_i!=0.
  - Increment and decrement of the same register in one cycle leaves the counter unchanged.
  - A decrement of a zero counter is ignored.
- RAW hazard: the operand is used, its address is nonzero, and its counter is nonzero. Exception with TRIUMPH_FWD_EN: the counter is 1 and WB writes that register this cycle.
- WAW hazard: id_rd_we_i and the rd counter is 3 (saturated).
- Issue: `id_issue_o = id_valid_i && state!=FLUSH && !flush_req_i && !ex_busy_i && !RAW && !WAW`.
- Stall: if_stall_o = id_valid_i && !id_issue_o && !flush_req_i && state!=FLUSH.
- FSM states are RUN, STALL and FLUSH.
  - RUN→STALL when a stall occurs.
  - STALL→RUN on the cycle id_issue_o is asserted.
  - Any state→FLUSH on flush_req_i; the flush counter loads FLUSH_CYCLES-1.
  - FLUSH→RUN when the flush counter reaches 0 and flush_req_i is low.
  - flush_req_i during FLUSH reloads the counter.
- id_flush_o is asserted when flush_req_i is high or state is FLUSH. id_issue_o and if_stall_o are 0 while it is asserted.
- A flush does not modify the scoreboard. In-flight older instructions still write back.
- stall_cnt_o increments on every cycle if_stall_o is 1 and saturates at all-ones.

## Timing
- Hazard, issue, stall, flush and forward outputs are combinational from the registered scoreboard/FSM and the current inputs. Issue decisions therefore have zero-cycle latency.
- Scoreboard updates are visible the cycle after issue or WB.
- Without forwarding, a dependent instruction issues the cycle after the producer's WB. With forwarding, it issues in the producer's WB cycle.
- Reset: scoreboard all zero, state RUN, flush counter 0, stall_cnt_o 0. All 1-bit outputs are forced to 0 while rst_i is low.
- Reset asserted mid-stall or mid-flush returns the block to RUN immediately, and pending writes are forgotten.

## Configuration
- TRIUMPH_FWD_EN defined: the WB-cycle RAW exception above applies, and fwd_rs1_o/fwd_rs2_o are driven high when the corresponding operand matches a WB write in that cycle (used, nonzero address).
- TRIUMPH_FWD_EN undefined: fwd_rs1_o/fwd_rs2_o are tied to 0, and every RAW hazard stalls until the counter reads 0.

## Structure
- The shared package triumph_pkg holds:
  - the FSM state encoding (RUN=2'd0, STALL=2'd1, FLUSH=2'd2);
  - REG_ADDR_W=5;
  - SB_CNT_W=2.
- Sub-module triumph_scoreboard holds the 31 counters, the set/clear logic and the per-operand pending/one-left query ports. The FSM, issue logic and stall counter live in the top.

## Test plan
- Back-to-back independent: issue `add x1` then `add x2,x3,x4` → id_issue_o=1 on both cycles, stall_cnt_o stays 0.
- RAW without forwarding: issue rd=x5, then an ID instruction reading rs1=x5; WB of x5 arrives 2 cycles later → if_stall_o=1 for 3 cycles, issue on the cycle after WB, stall_cnt_o=3.
- RAW with TRIUMPH_FWD_EN, same stimulus → issue in the WB cycle with fwd_rs1_o=1, stall_cnt_o=2.
- x0 handling: an instruction writing x0, followed by one reading x0 → no stall, and the scoreboard stays zero.
- Flush: flush_req_i pulsed while ID is stalled on a RAW hazard → id_flush_o=1 for 1+FLUSH_CYCLES cycles (3 at default), no issue, scoreboard unchanged, then state returns to RUN.
- WAW saturation, with ex_busy_i also covered: 3 writes to x7 without WB, then a 4th write to x7 → stall until one WB. Separately, ex_busy_i=1 → id_issue_o=0 and if_stall_o=1 until it drops.
